// File: rtl/bp_resolve.sv
// Branch-prediction resolver: queues fetch-stage predictions, compares them against
// exe-stage outcomes, and raises a one-cycle redirect/flush plus predictor training pulses.
//
// state  | meaning
// NORMAL | queue accepts pushes, exe results resolved against the queue head
// FLUSH  | redirect/flush asserted for one cycle, queue held empty
module bp_resolve #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        pred_valid,
   input  logic [31:0] pred_pc,
   input  logic        pred_taken,
   input  logic [31:0] pred_target,
   output logic        pred_ready,
   input  logic        exe_valid,
   input  logic [31:0] exe_pc,
   input  logic [2:0]  exe_kind,
   input  logic        exe_taken,
   input  logic [31:0] exe_target,
   input  logic        stall,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        upd_branch,
   output logic        upd_j,
   output logic        upd_jal,
   output logic        upd_jalr,
   output logic        upd_jr_ra,
   output logic        upd_jr_not_ra,
   output logic [31:0] upd_pc,
   output logic [31:0] upd_dest,
   output logic [31:0] upd_ret,
   output logic        upd_taken,
   output logic [31:0] mispred_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic {NORMAL, FLUSH} state_t;

   state_t          state;
   logic [31:0]     q_pc     [DEPTH];
   logic            q_taken  [DEPTH];
   logic [31:0]     q_target [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [AW:0]     count;

   logic            exe_acc, hit, push, pop, mispred;
   logic            eff_taken;
   logic [31:0]     eff_target, fall_pc;

   assign pred_ready = (count != FULL);
   assign fall_pc    = exe_pc + 32'd8;
   assign exe_acc    = exe_valid && !stall && (state == NORMAL) && (exe_kind <= 3'd5);
   assign hit        = (count != '0) && (q_pc[rd_ptr] == exe_pc);
   assign push       = pred_valid && pred_ready && (state == NORMAL);
   assign pop        = exe_acc && hit;

   // An unmatched or empty head resolves as a not-taken prediction.
   assign eff_taken  = hit ? q_taken[rd_ptr]  : 1'b0;
   assign eff_target = hit ? q_target[rd_ptr] : fall_pc;
   assign mispred    = (exe_taken != eff_taken) ||
                       (exe_taken && eff_taken && (exe_target != eff_target));

   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]     <= pred_pc;
         q_taken[wr_ptr]  <= pred_taken;
         q_target[wr_ptr] <= pred_target;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= NORMAL;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         redirect      <= 1'b0;
         flush         <= 1'b0;
         redirect_pc   <= '0;
         upd_branch    <= 1'b0;
         upd_j         <= 1'b0;
         upd_jal       <= 1'b0;
         upd_jalr      <= 1'b0;
         upd_jr_ra     <= 1'b0;
         upd_jr_not_ra <= 1'b0;
         upd_pc        <= '0;
         upd_dest      <= '0;
         upd_ret       <= '0;
         upd_taken     <= 1'b0;
         mispred_cnt   <= '0;
      end else begin
         upd_branch    <= exe_acc && (exe_kind == 3'd0);
         upd_j         <= exe_acc && (exe_kind == 3'd1);
         upd_jal       <= exe_acc && (exe_kind == 3'd2);
         upd_jalr      <= exe_acc && (exe_kind == 3'd3);
         upd_jr_ra     <= exe_acc && (exe_kind == 3'd4);
         upd_jr_not_ra <= exe_acc && (exe_kind == 3'd5);
         if (exe_acc) begin
            upd_pc    <= exe_pc;
            upd_dest  <= exe_target;
            upd_ret   <= fall_pc;
            upd_taken <= (exe_kind == 3'd0) ? exe_taken : 1'b1;
         end

         case (state)
            NORMAL: begin
               if (exe_acc && mispred) begin
                  // Wrong-path records are discarded together with the redirect.
                  state       <= FLUSH;
                  redirect    <= 1'b1;
                  flush       <= 1'b1;
                  redirect_pc <= exe_taken ? exe_target : fall_pc;
                  rd_ptr      <= '0;
                  wr_ptr      <= '0;
                  count       <= '0;
                  if (mispred_cnt != 32'hFFFF_FFFF)
                     mispred_cnt <= mispred_cnt + 32'd1;
               end else begin
                  if (push) wr_ptr <= wr_ptr + AW'(1);
                  if (pop)  rd_ptr <= rd_ptr + AW'(1);
                  case ({push, pop})
                     2'b10:   count <= count + (AW+1)'(1);
                     2'b01:   count <= count - (AW+1)'(1);
                     default: count <= count;
                  endcase
               end
            end
            FLUSH: begin
               state    <= NORMAL;
               redirect <= 1'b0;
               flush    <= 1'b0;
               rd_ptr   <= '0;
               wr_ptr   <= '0;
               count    <= '0;
            end
            default: state <= NORMAL;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_resolve.sv
// Directed bench for bp_resolve: vector table for single resolutions plus
// sequences for queue fill/wrap, stalled mispredict and reset during flush.
module tb_bp_resolve;

   logic        clk = 1'b0;
   logic        resetn;
   logic        pred_valid, pred_taken, pred_ready;
   logic [31:0] pred_pc, pred_target;
   logic        exe_valid, exe_taken, stall;
   logic [31:0] exe_pc, exe_target;
   logic [2:0]  exe_kind;
   logic        redirect, flush;
   logic [31:0] redirect_pc;
   logic        upd_branch, upd_j, upd_jal, upd_jalr, upd_jr_ra, upd_jr_not_ra;
   logic [31:0] upd_pc, upd_dest, upd_ret;
   logic        upd_taken;
   logic [31:0] mispred_cnt;

   int total = 0;
   int bad   = 0;
   int emc   = 0;

   bp_resolve #(.DEPTH(8)) dut (
      .clk(clk), .resetn(resetn),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .pred_ready(pred_ready),
      .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_kind(exe_kind),
      .exe_taken(exe_taken), .exe_target(exe_target), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
      .upd_branch(upd_branch), .upd_j(upd_j), .upd_jal(upd_jal),
      .upd_jalr(upd_jalr), .upd_jr_ra(upd_jr_ra), .upd_jr_not_ra(upd_jr_not_ra),
      .upd_pc(upd_pc), .upd_dest(upd_dest), .upd_ret(upd_ret),
      .upd_taken(upd_taken), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   logic [5:0] upd_vec;
   assign upd_vec = {upd_jr_not_ra, upd_jr_ra, upd_jalr, upd_jal, upd_j, upd_branch};

   typedef struct {
      logic        pv;
      logic [31:0] ppc;
      logic        ptk;
      logic [31:0] ptgt;
      logic [31:0] epc;
      logic [2:0]  kind;
      logic        etk;
      logic [31:0] etgt;
      logic        redir;
      logic [31:0] rpc;
      logic [5:0]  upd;
      logic [31:0] ret;
      logic        utk;
      int          cnt;
   } vec_t;

   vec_t vt[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] fpc(input int i);
      return 32'h1000 + 32'(4 * i);
   endfunction

   initial begin
      int pushed, popped;

      resetn = 1'b0; pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
      exe_valid = 0; exe_pc = 0; exe_kind = 0; exe_taken = 0; exe_target = 0; stall = 0;
      #3;
      chk("rst_redirect", 32'(redirect), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_rpc", redirect_pc, 0);
      chk("rst_ready", 32'(pred_ready), 1);
      chk("rst_upd", 32'(upd_vec), 0);
      chk("rst_cnt", mispred_cnt, 0);
      #9 resetn = 1'b1;
      step();

      //        pv  ppc           ptk ptgt          epc           kind etk etgt         redir rpc          upd       ret           utk cnt
      vt[0]  = '{1, 32'h100,      1,  32'h200,      32'h100,      0,   1,  32'h200,     0,    32'h0,       6'b000001, 32'h108,     1,  0};
      vt[1]  = '{1, 32'h100,      0,  32'h108,      32'h100,      0,   1,  32'h300,     1,    32'h300,     6'b000001, 32'h108,     1,  0};
      vt[2]  = '{0, 32'h0,        0,  32'h0,        32'h400,      2,   1,  32'h800,     1,    32'h800,     6'b000100, 32'h408,     1,  0};
      vt[3]  = '{1, 32'h500,      0,  32'h508,      32'h500,      0,   0,  32'h600,     0,    32'h0,       6'b000001, 32'h508,     0,  0};
      vt[4]  = '{1, 32'h600,      1,  32'h700,      32'h600,      0,   0,  32'h700,     1,    32'h608,     6'b000001, 32'h608,     0,  0};
      vt[5]  = '{1, 32'h700,      1,  32'h900,      32'h700,      3,   1,  32'hA00,     1,    32'hA00,     6'b001000, 32'h708,     1,  0};
      vt[6]  = '{1, 32'h800,      1,  32'h1000,     32'h800,      1,   1,  32'h1000,    0,    32'h0,       6'b000010, 32'h808,     1,  0};
      vt[7]  = '{1, 32'h900,      1,  32'h44,       32'h900,      4,   1,  32'h44,      0,    32'h0,       6'b010000, 32'h908,     1,  0};
      vt[8]  = '{1, 32'hA00,      1,  32'h50,       32'hB00,      5,   1,  32'h60,      1,    32'h60,      6'b100000, 32'hB08,     1,  0};
      vt[9]  = '{0, 32'h0,        0,  32'h0,        32'hC00,      0,   0,  32'hD00,     0,    32'h0,       6'b000001, 32'hC08,     0,  0};
      vt[10] = '{0, 32'h0,        0,  32'h0,        32'hFFFFFFFC, 0,   0,  32'h10,      0,    32'h0,       6'b000001, 32'h4,       0,  0};
      vt[11] = '{1, 32'hFFFFFFF8, 1,  32'h20,       32'hFFFFFFF8, 0,   0,  32'h20,      1,    32'h0,       6'b000001, 32'h0,       0,  0};
      vt[12] = '{1, 32'hD00,      1,  32'hE00,      32'hD00,      6,   1,  32'hE00,     0,    32'h0,       6'b000000, 32'h0,       0,  1};
      vt[13] = '{0, 32'h0,        0,  32'h0,        32'hD00,      0,   1,  32'hE00,     0,    32'h0,       6'b000001, 32'hD08,     1,  0};
      vt[14] = '{1, 32'hE00,      1,  32'hF00,      32'hE00,      0,   1,  32'hF04,     1,    32'hF04,     6'b000001, 32'hE08,     1,  0};

      for (int i = 0; i < 15; i++) begin
         if (vt[i].pv) begin
            pred_valid = 1; pred_pc = vt[i].ppc; pred_taken = vt[i].ptk; pred_target = vt[i].ptgt;
            step();
            pred_valid = 0;
         end
         exe_valid = 1; exe_pc = vt[i].epc; exe_kind = vt[i].kind;
         exe_taken = vt[i].etk; exe_target = vt[i].etgt;
         step();
         exe_valid = 0;
         if (vt[i].redir) emc++;
         chk($sformatf("v%0d_redirect", i), 32'(redirect), 32'(vt[i].redir));
         chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vt[i].redir));
         if (vt[i].redir) chk($sformatf("v%0d_rpc", i), redirect_pc, vt[i].rpc);
         chk($sformatf("v%0d_upd", i), 32'(upd_vec), 32'(vt[i].upd));
         if (vt[i].upd != 0) begin
            chk($sformatf("v%0d_upd_pc", i), upd_pc, vt[i].epc);
            chk($sformatf("v%0d_upd_dest", i), upd_dest, vt[i].etgt);
            chk($sformatf("v%0d_upd_ret", i), upd_ret, vt[i].ret);
            chk($sformatf("v%0d_upd_taken", i), 32'(upd_taken), 32'(vt[i].utk));
         end
         chk($sformatf("v%0d_mcnt", i), mispred_cnt, 32'(emc));
         chk($sformatf("v%0d_count", i), 32'(dut.count), 32'(vt[i].cnt));
         step();
         chk($sformatf("v%0d_redirect_after", i), 32'(redirect), 0);
         chk($sformatf("v%0d_upd_after", i), 32'(upd_vec), 0);
      end

      // Fill to full, overflow push, then push+pop streaming over several pointer laps.
      pred_valid = 1; pred_taken = 1;
      for (int i = 0; i < 8; i++) begin
         pred_pc = fpc(i); pred_target = fpc(i) + 32'h40;
         step();
      end
      chk("fill_ready", 32'(pred_ready), 0);
      chk("fill_count", 32'(dut.count), 8);
      pred_pc = 32'h2000; pred_target = 32'h2040;
      step();
      chk("overflow_count", 32'(dut.count), 8);
      pushed = 8; popped = 0;
      pred_pc = fpc(pushed); pred_target = fpc(pushed) + 32'h40;
      exe_valid = 1; exe_kind = 0; exe_taken = 1;
      exe_pc = fpc(popped); exe_target = fpc(popped) + 32'h40;
      step();
      popped++;
      chk("full_pushpop_count", 32'(dut.count), 7);
      chk("full_pushpop_redirect", 32'(redirect), 0);
      for (int i = 0; i < 24; i++) begin
         pred_pc = fpc(pushed); pred_target = fpc(pushed) + 32'h40;
         exe_pc = fpc(popped); exe_target = fpc(popped) + 32'h40;
         step();
         pushed++; popped++;
         chk($sformatf("lap%0d_redirect", i), 32'(redirect), 0);
         chk($sformatf("lap%0d_count", i), 32'(dut.count), 7);
         chk($sformatf("lap%0d_upd_pc", i), upd_pc, fpc(popped - 1));
      end
      pred_valid = 0;
      for (int i = 0; i < 7; i++) begin
         exe_pc = fpc(popped); exe_target = fpc(popped) + 32'h40;
         step();
         popped++;
         chk($sformatf("drain%0d_redirect", i), 32'(redirect), 0);
      end
      exe_valid = 0;
      chk("drain_count", 32'(dut.count), 0);
      chk("drain_mcnt", mispred_cnt, 32'(emc));
      step();

      // Mispredict held under stall resolves exactly once.
      pred_valid = 1; pred_pc = 32'h3000; pred_taken = 0; pred_target = 32'h3008;
      step();
      pred_valid = 0;
      exe_valid = 1; exe_pc = 32'h3000; exe_kind = 0; exe_taken = 1; exe_target = 32'h3100;
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stall%0d_redirect", i), 32'(redirect), 0);
         chk($sformatf("stall%0d_count", i), 32'(dut.count), 1);
         chk($sformatf("stall%0d_upd", i), 32'(upd_vec), 0);
      end
      stall = 0;
      step();
      exe_valid = 0;
      emc++;
      chk("unstall_redirect", 32'(redirect), 1);
      chk("unstall_rpc", redirect_pc, 32'h3100);
      chk("unstall_mcnt", mispred_cnt, 32'(emc));
      step();
      chk("unstall_redirect_once", 32'(redirect), 0);

      // Reset asserted during FLUSH drops the redirect immediately.
      exe_valid = 1; exe_pc = 32'h4000; exe_kind = 2; exe_taken = 1; exe_target = 32'h5000;
      step();
      exe_valid = 0;
      chk("pre_reset_redirect", 32'(redirect), 1);
      #2 resetn = 1'b0;
      #1;
      emc = 0;
      chk("reset_flush_redirect", 32'(redirect), 0);
      chk("reset_flush_flush", 32'(flush), 0);
      chk("reset_flush_upd", 32'(upd_vec), 0);
      chk("reset_flush_mcnt", mispred_cnt, 32'(emc));
      chk("reset_flush_ready", 32'(pred_ready), 1);
      #3 resetn = 1'b1;
      step();
      chk("post_reset_redirect", 32'(redirect), 0);
      chk("post_reset_count", 32'(dut.count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
